// File: rtl/instr_mem_loader.sv
// Length-prefixed, XOR-checksummed byte-stream loader that fills instruction memory with big-endian words.
// Optional per-byte idle timeout is built when LOADER_TIMEOUT_EN is defined.
module instr_mem_loader #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  lane_q;
    logic [23:0] word_q;
    logic [7:0]  csum_q;

    logic        accept_c;
    logic [15:0] len_c;
    logic        last_word_c;
    logic        active_d_c;
    logic        timeout_c;

    assign accept_c    = byte_valid && byte_ready;
    assign len_c       = {len_hi_q, byte_data};
    assign last_word_c = (lane_q == 2'd3) && ((idx_q + 16'd1) == len_q);
    assign active_d_c  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                         (state_d == S_DATA)   || (state_d == S_CHECK);

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign timeout_c = (tmo_q == TW'(TIMEOUT));

    // Idle-cycle counter; restarts on every accepted byte and every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (accept_c || (state_d != state_q) || !byte_ready) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
            S_LEN_HI: if (accept_c) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (accept_c) begin
                    if (len_c > 16'(DEPTH))  state_d = S_ERR;
                    else if (len_c == 16'd0) state_d = S_CHECK;
                    else                     state_d = S_DATA;
                end
            end
            S_DATA:  if (accept_c && last_word_c) state_d = S_CHECK;
            S_CHECK: if (accept_c) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (timeout_c) state_d = S_ERR;
    end

    // State, registered status outputs and word assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state_q    <= state_d;
            byte_ready <= active_d_c;
            cpu_hold   <= active_d_c;
            done       <= (state_d == S_DONE);
            error      <= (state_d == S_ERR);
            wr_en      <= 1'b0;

            if ((state_d == S_LEN_HI) && (state_q != S_LEN_HI)) begin
                csum_q <= '0;
                idx_q  <= '0;
                lane_q <= '0;
            end

            if (accept_c) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= byte_data;
                    S_LEN_LO: len_q    <= len_c;
                    S_DATA: begin
                        word_q <= {word_q[15:0], byte_data};
                        csum_q <= csum_q ^ byte_data;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_addr <= {16'b0, idx_q};
                            wr_data <= {word_q, byte_data};
                            idx_q   <= idx_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a stream-level reference model.
module tb_instr_mem_loader;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_wcyc[$];
    bit          exp_done;
    bit          exp_err;

    instr_mem_loader #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: decode a whole stream into expected writes and final status
    task automatic model(input logic [7:0] s[$]);
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'({s[0], s[1]});
        if (n > int'(DEPTH)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(32'(w));
            exp_data.push_back({s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
            for (int b = 0; b < 4; b++) x = x ^ s[2+4*w+b];
        end
        if (s[2+4*n] == x) exp_done = 1'b1;
        else               exp_err  = 1'b1;
    endtask

    task automatic gen_stream(input int n, input bit corrupt, output logic [7:0] q[$]);
        logic [7:0] x;
        logic [7:0] b;
        q = {};
        x = 8'h00;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x = x ^ b;
        end
        q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    task automatic send(input logic [7:0] s[$], input bit rnd, input bit mid_start);
        int n;
        int budget;
        bit acc;
        bit pulsed;
        n = int'({s[0], s[1]});
        exp_wcyc.delete();
        pulsed = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            acc    = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                byte_data  = s[i];
                byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                start      = 1'b0;
                if (mid_start && !pulsed && i == 4) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
                acc = byte_valid && (byte_ready === 1'b1);
                if (acc && n <= int'(DEPTH) && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
                    exp_wcyc.push_back(cyc + 1);
                budget++;
                if (!acc && budget > 60) begin
                    total++; bad++;
                    $display("FAIL send_stall byte %0d: byte_ready=%b, required 1", i, byte_ready);
                    byte_valid = 1'b0;
                    start      = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        total++;
        if ({byte_ready, cpu_hold, done, error} !== 4'b1100) begin
            bad++;
            $display("FAIL start_entry: ready/hold/done/err=%b, required 1100",
                     {byte_ready, cpu_hold, done, error});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({byte_ready, wr_en, cpu_hold, done, error} !== 5'b0) begin
            bad++;
            $display("FAIL %s_flags: ready/wr_en/hold/done/err=%b, required 00000", name,
                     {byte_ready, wr_en, cpu_hold, done, error});
        end
        total++;
        if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            bad++;
            $display("FAIL %s_wrbus: addr=%h data=%h, required 0/0", name, wr_addr, wr_data);
        end
    endtask

    // Called at the negedge where the final byte was driven: checks the cycle after its acceptance
    task automatic check_result(input string name);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        total++;
        if (done !== exp_done || error !== exp_err) begin
            bad++;
            $display("FAIL %s_status: done=%b error=%b, required done=%b error=%b",
                     name, done, error, exp_done, exp_err);
        end
        total++;
        if (cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: cpu_hold=%b byte_ready=%b, required 0 0", name, cpu_hold, byte_ready);
        end
        total++;
        if (obs_addr.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL %s_wcount: writes=%0d, required %0d", name, obs_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                total++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL %s_write%0d: addr=%h data=%h, required addr=%h data=%h",
                             name, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
                total++;
                if (i < exp_wcyc.size() && obs_cyc[i] !== exp_wcyc[i]) begin
                    bad++;
                    $display("FAIL %s_wtime%0d: cycle=%0d, required %0d", name, i, obs_cyc[i], exp_wcyc[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
    endtask

    task automatic test_normal();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        model(s);
        do_start();
        send(s, 1'b0, 1'b0);
        check_result("normal");
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F};
        model(s);
        do_start();
        send(s, 1'b0, 1'b0);
        check_result("badsum");
    endtask

    task automatic test_boundary_lengths();
        logic [7:0] s[$];
        s = '{8'h00, 8'h00, 8'h00};
        model(s);
        do_start();
        send(s, 1'b0, 1'b0);
        check_result("len0");
        s = '{8'h01, 8'h01};
        model(s);
        do_start();
        send(s, 1'b0, 1'b0);
        check_result("oversize");
        gen_stream(int'(DEPTH), 1'b0, s);
        model(s);
        do_start();
        send(s, 1'b0, 1'b0);
        check_result("fullsize");
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        s = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        do_start();
        send(s, 1'b0, 1'b0);
        do_reset();
        check_zero("rst_mid");
        total++;
        if (obs_addr.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_nowrite: writes=%0d, required 0", obs_addr.size());
        end
        gen_stream(3, 1'b0, s);
        model(s);
        do_start();
        send(s, 1'b0, 1'b0);
        check_result("after_rst");
    endtask

    task automatic test_stalls();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        model(s);
        do_start();
        send(s, 1'b1, 1'b1);
        check_result("stalls");
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        for (int k = 0; k < 6; k++) begin
            gen_stream(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), s);
            model(s);
            do_start();
            send(s, 1'($urandom_range(0, 1)), 1'b0);
            check_result($sformatf("b2b%0d", k));
        end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_idle();
        logic [7:0] s[$];
        int k;
        s = '{8'h00};
        do_start();
        send(s, 1'b0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        k = 1;
        while (error !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k != 18) begin
            bad++;
            $display("FAIL timeout_latency: error after %0d cycles, required 18", k);
        end
    endtask
`else
    task automatic test_idle();
        logic [7:0] s[$];
        s = '{8'h00};
        do_start();
        send(s, 1'b0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (error !== 1'b0 || byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL idle_wait: error=%b ready=%b hold=%b, required 0 1 1", error, byte_ready, cpu_hold);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_bad_checksum();
        test_boundary_lengths();
        test_reset_mid();
        test_stalls();
        test_back_to_back();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream loader that writes a program image into the processor's instruction memory before execution. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through a word-addressed write port whose indexing matches the instruction memory read address. While loading, it holds the processor core stalled, and it reports completion or failure.

## Interface
- DEPTH, 256, instruction memory size in words; maximum accepted word count
- TIMEOUT, 1024, idle-cycle limit per byte; used only when LOADER_TIMEOUT_EN is defined
- clk  input  1  clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  single-cycle instruction memory write strobe
- wr_addr  output  32  word index, zero-extended
- wr_data  output  32  assembled instruction word
- cpu_hold  output  1  stall/hold for the core while a load is in progress
- done  output  1  load completed with a good checksum; sticky
- error  output  1  load failed; sticky

## Operation
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- Stream format:
  - length high byte, then length low byte: N words, unsigned 16-bit.
  - 4·N data bytes, most-significant byte of each word first.
  - one checksum byte, equal to the XOR of all data bytes. The length bytes are excluded.
- States:
  - IDLE: start → LEN_HI.
  - LEN_HI: accept byte → LEN_LO.
  - LEN_LO: accept byte. N > DEPTH → ERR. N = 0 → CHECK. Otherwise → DATA.
  - DATA: 4th byte of word N−1 accepted → CHECK.
  - CHECK: accept byte. Match → DONE. Mismatch → ERR.
  - DONE and ERR: hold until start, which → LEN_HI, or rst.
- byte_ready is 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE, DONE and ERR.
- cpu_hold is 1 in every state except IDLE, DONE and ERR.
- Word index counter:
  - Width is 16 bits and it starts at 0 per load.
  - It increments after each write.
  - wr_addr = {16'b0, index}.
- Byte-lane counter: 2 bits, wraps 3→0 on each data byte.
- The checksum accumulator is cleared on entry to LEN_HI.
- start while in LEN_HI..CHECK is ignored.
- byte_valid is ignored when byte_ready = 0.

## Timing
- Reset values:
  - All outputs 0: byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error.
  - State IDLE; all counters and the accumulator 0.
- rst mid-load: the next cycle is IDLE with all outputs 0. A partially assembled word is discarded and never written.
- start at edge t: the state is LEN_HI and byte_ready = cpu_hold = 1 from t+1.
- Write timing:
  - wr_en pulses for exactly one cycle, the cycle after the edge accepting a word's 4th byte.
  - wr_addr and wr_data are valid in that cycle and hold their values afterwards.
  - Back-to-back words may produce wr_en in consecutive-word cycles spaced ≥4 cycles apart. No write coalescing.
- Completion timing:
  - done or error rises the cycle after the edge accepting the checksum byte, or the low length byte for an oversize N.
  - cpu_hold falls in that same cycle.
- done and error are never both 1. Both clear in the cycle after a restarting start.
- Throughput: one byte per cycle when byte_valid is held high.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A counter counts consecutive cycles in LEN_HI..CHECK with no accepted byte.
  - Reaching TIMEOUT → ERR, with error = 1 the next cycle.
  - The counter clears on every accepted byte and on state entry.
- LOADER_TIMEOUT_EN undefined:
  - No counter is built; the loader waits indefinitely for bytes.
  - The TIMEOUT parameter is unused.

## Test plan
- Normal load:
  - Stimulus: after rst, start, then bytes 00 02 20 08 00 05 20 09 00 0A 0E at one per cycle.
  - Required: wr_en pulses with (addr 0, 0x20080005) and (addr 1, 0x2009000A), then done = 1, error = 0, cpu_hold = 0.
- Bad checksum:
  - Stimulus: the same stream with checksum 0x0F.
  - Required: both writes occur, then error = 1, done = 0.
- Boundary lengths:
  - N = 0, stream 00 00 00: no wr_en, then done = 1.
  - N = 257, stream 01 01: error = 1 one cycle after the 2nd byte, byte_ready = 0, no writes.
- Reset mid-load:
  - Stimulus: rst after 2 data bytes of word 0.
  - Required: no wr_en, all outputs 0. A following full load starts at wr_addr 0.
- Stalls and start handling:
  - Stimulus: byte_valid toggled randomly across the normal load, plus start pulsed mid-DATA.
  - Required: identical writes and done as in the normal load; the start has no effect.
- Timeout (LOADER_TIMEOUT_EN defined, TIMEOUT = 16):
  - Stimulus: start, send 00 only, then idle.
  - Required: error = 1 exactly 17 cycles after the last accepted byte.
